// File: rtl/op_exec_unit.sv
// Handshaked execution unit: logic ops, INC/ADD, shifts/rotates, SWAP, NOP, TRAP.
// Define OPEXEC_BARREL_SHIFT_EN to compute shifts/rotates in one cycle instead of one bit per cycle.
module op_exec_unit #(
  parameter int WIDTH   = 20,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] w,
  output logic             wen,
  output logic             wsel,
  output logic             carry,
  output logic             illegal,
  output logic             halted
);

  localparam logic [4:0] OP_TRAP  = 5'd0;
  localparam logic [4:0] OP_NOP   = 5'd1;
  localparam logic [4:0] OP_NOT   = 5'd8;
  localparam logic [4:0] OP_AND   = 5'd9;
  localparam logic [4:0] OP_OR    = 5'd10;
  localparam logic [4:0] OP_XOR   = 5'd11;
  localparam logic [4:0] OP_SHFTR = 5'd12;
  localparam logic [4:0] OP_SHFTL = 5'd13;
  localparam logic [4:0] OP_ROTR  = 5'd14;
  localparam logic [4:0] OP_ROTL  = 5'd15;
  localparam logic [4:0] OP_SWAP  = 5'd16;
  localparam logic [4:0] OP_INC   = 5'd17;
  localparam logic [4:0] OP_ADD   = 5'd18;

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // a presented beat (out_valid) keeps every output stable until out_ready accepts it.
  typedef enum logic [2:0] {
    S_IDLE,
    S_OUT,
    S_OUT2,
    S_HALT
`ifndef OPEXEC_BARREL_SHIFT_EN
    , S_SHIFT
`endif
  } state_t;

  state_t state, state_next;

  logic [4:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] w_q;
  logic             wen_q, wsel_q, carry_q, illegal_q;

  logic [WIDTH-1:0] issue_w;
  logic             issue_wen, issue_carry, issue_illegal;
  logic [WIDTH:0]   sum;
  logic [31:0]      n_amt, rot_amt, shf_steps;

`ifdef OPEXEC_BARREL_SHIFT_EN
  logic [2*WIDTH-1:0] dbl;
`else
  localparam int CNT_W = $clog2(WIDTH + 1);
  logic [CNT_W-1:0] cnt_q, issue_cnt;
  logic [WIDTH-1:0] step_w;
  logic             shift_op;
`endif

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_OUT) || (state == S_OUT2);
  assign halted    = (state == S_HALT);
  assign w         = w_q;
  assign wen       = wen_q;
  assign wsel      = wsel_q;
  assign carry     = carry_q;
  assign illegal   = illegal_q;

  // Result decode for the op being issued; shifts either resolve here or seed the iterative path.
  always_comb begin
    n_amt         = 32'(b[SHAMT_W-1:0]);
    rot_amt       = n_amt % 32'(WIDTH);
    shf_steps     = (n_amt >= 32'(WIDTH)) ? 32'(WIDTH) : n_amt;
    sum           = '0;
    issue_w       = '0;
    issue_wen     = 1'b0;
    issue_carry   = 1'b0;
    issue_illegal = 1'b0;
`ifdef OPEXEC_BARREL_SHIFT_EN
    dbl           = '0;
`else
    issue_cnt     = '0;
`endif
    case (opcode)
      OP_TRAP, OP_NOP: ;
      OP_NOT: begin issue_w = ~a;    issue_wen = 1'b1; end
      OP_AND: begin issue_w = a & b; issue_wen = 1'b1; end
      OP_OR:  begin issue_w = a | b; issue_wen = 1'b1; end
      OP_XOR: begin issue_w = a ^ b; issue_wen = 1'b1; end
`ifdef OPEXEC_BARREL_SHIFT_EN
      OP_SHFTR: begin
        issue_wen = 1'b1;
        issue_w   = (n_amt >= 32'(WIDTH)) ? '0 : (a >> n_amt);
      end
      OP_SHFTL: begin
        issue_wen = 1'b1;
        issue_w   = (n_amt >= 32'(WIDTH)) ? '0 : (a << n_amt);
      end
      OP_ROTR: begin
        issue_wen = 1'b1;
        dbl       = {a, a} >> rot_amt;
        issue_w   = dbl[WIDTH-1:0];
      end
      OP_ROTL: begin
        issue_wen = 1'b1;
        dbl       = {a, a} << rot_amt;
        issue_w   = dbl[2*WIDTH-1:WIDTH];
      end
`else
      OP_SHFTR, OP_SHFTL: begin
        issue_wen = 1'b1;
        issue_w   = a;
        issue_cnt = CNT_W'(shf_steps);
      end
      OP_ROTR, OP_ROTL: begin
        issue_wen = 1'b1;
        issue_w   = a;
        issue_cnt = CNT_W'(rot_amt);
      end
`endif
      OP_SWAP: begin issue_w = b; issue_wen = 1'b1; end
      OP_INC: begin
        sum         = {1'b0, a} + (WIDTH+1)'(1);
        issue_w     = sum[WIDTH-1:0];
        issue_carry = sum[WIDTH];
        issue_wen   = 1'b1;
      end
      OP_ADD: begin
        sum         = {1'b0, a} + {1'b0, b};
        issue_w     = sum[WIDTH-1:0];
        issue_carry = sum[WIDTH];
        issue_wen   = 1'b1;
      end
      default: issue_illegal = 1'b1;
    endcase
  end

`ifndef OPEXEC_BARREL_SHIFT_EN
  assign shift_op = (opcode[4:2] == 3'b011);

  // op_q[1:0] distinguishes SHFTR/SHFTL/ROTR/ROTL within the 12..15 group.
  always_comb begin
    step_w = w_q;
    case (op_q[1:0])
      2'b00: step_w = w_q >> 1;
      2'b01: step_w = w_q << 1;
      2'b10: step_w = {w_q[0], w_q[WIDTH-1:1]};
      2'b11: step_w = {w_q[WIDTH-2:0], w_q[WIDTH-1]};
      default: step_w = w_q;
    endcase
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
`ifdef OPEXEC_BARREL_SHIFT_EN
          state_next = S_OUT;
`else
          state_next = (shift_op && (issue_cnt != '0)) ? S_SHIFT : S_OUT;
`endif
        end
      end
`ifndef OPEXEC_BARREL_SHIFT_EN
      S_SHIFT: if (cnt_q == CNT_W'(1)) state_next = S_OUT;
`endif
      S_OUT: begin
        if (out_ready) begin
          if (op_q == OP_SWAP)      state_next = S_OUT2;
          else if (op_q == OP_TRAP) state_next = S_HALT;
          else                      state_next = S_IDLE;
        end
      end
      S_OUT2:  if (out_ready) state_next = S_IDLE;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      a_q       <= '0;
      w_q       <= '0;
      wen_q     <= 1'b0;
      wsel_q    <= 1'b0;
      carry_q   <= 1'b0;
      illegal_q <= 1'b0;
`ifndef OPEXEC_BARREL_SHIFT_EN
      cnt_q     <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_q      <= opcode;
            a_q       <= a;
            w_q       <= issue_w;
            wen_q     <= issue_wen;
            wsel_q    <= 1'b0;
            carry_q   <= issue_carry;
            illegal_q <= issue_illegal;
`ifndef OPEXEC_BARREL_SHIFT_EN
            cnt_q     <= issue_cnt;
`endif
          end
        end
`ifndef OPEXEC_BARREL_SHIFT_EN
        S_SHIFT: begin
          w_q   <= step_w;
          cnt_q <= cnt_q - CNT_W'(1);
        end
`endif
        S_OUT: begin
          // SWAP's second beat writes A's value into B's register.
          if (out_ready && (op_q == OP_SWAP)) begin
            w_q    <= a_q;
            wsel_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
